uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets three byte producers share one UART transmitter.
// A requester keeps ownership across bytes until it sends a byte flagged as the last of its message.
module uart_tx_arbiter #(
    parameter int BUSY_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [2:0]       req_valid,
    input  logic [23:0]      req_data,
    input  logic [2:0]       req_last,
    output logic [2:0]       req_ready,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_busy,
    output logic [2:0]       grant,
    output logic             err_timeout,
    output logic [CNT_W-1:0] byte_cnt
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam int TO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    logic [1:0]      state_q;
    logic [1:0]      owner_q;
    logic [1:0]      rr_last_q;
    logic            last_q;
    logic [TO_W-1:0] to_cnt_q;

    logic [1:0] cand1;
    logic [1:0] cand2;
    logic       pick_valid;
    logic [1:0] pick_idx;
    logic [2:0] pick_onehot;
    logic       grant_en;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Search order starts just after the last released owner.
    assign cand1 = next_idx(rr_last_q);
    assign cand2 = next_idx(cand1);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = owner_q;
        if (|grant) begin
            pick_valid = req_valid[owner_q];
        end else if (req_valid[cand1]) begin
            pick_valid = 1'b1;
            pick_idx   = cand1;
        end else if (req_valid[cand2]) begin
            pick_valid = 1'b1;
            pick_idx   = cand2;
        end else if (req_valid[rr_last_q]) begin
            pick_valid = 1'b1;
            pick_idx   = rr_last_q;
        end
    end

    assign pick_onehot = 3'b001 << pick_idx;
    assign grant_en    = (state_q == IDLE) && !tx_busy && pick_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= IDLE;
            owner_q     <= 2'd0;
            rr_last_q   <= 2'd2;
            last_q      <= 1'b0;
            to_cnt_q    <= '0;
            req_ready   <= 3'b000;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            grant       <= 3'b000;
            err_timeout <= 1'b0;
            byte_cnt    <= '0;
        end else begin
            req_ready <= 3'b000;
            tx_start  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_en) begin
                        req_ready <= pick_onehot;
                        grant     <= pick_onehot;
                        owner_q   <= pick_idx;
                        tx_data   <= req_data[{pick_idx, 3'b000} +: 8];
                        last_q    <= req_last[pick_idx];
                        state_q   <= START;
                    end
                end
                START: begin
                    tx_start <= 1'b1;
                    to_cnt_q <= '0;
                    state_q  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
                        // Transmitter never acknowledged: drop the owner so others are not starved.
                        err_timeout <= 1'b1;
                        grant       <= 3'b000;
                        rr_last_q   <= owner_q;
                        state_q     <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        state_q  <= IDLE;
                        if (last_q) begin
                            grant     <= 3'b000;
                            rr_last_q <= owner_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester and UART models, a message-level round-robin
// model that predicts the transmitted byte stream, and directed scenarios with literal checks.
module tb_uart_tx_arbiter;

    localparam int BUSY_TIMEOUT = 16;
    localparam int CNT_W        = 4;
    localparam int UART_CYC     = 10;

    typedef struct packed {
        logic [1:0] src;
        logic       last;
        logic [7:0] data;
    } item_t;

    logic             clock     = 1'b0;
    logic             resetb    = 1'b0;
    logic [2:0]       req_valid = 3'b000;
    logic [23:0]      req_data  = 24'h0;
    logic [2:0]       req_last  = 3'b000;
    logic             tx_busy   = 1'b0;
    logic [2:0]       req_ready;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic [2:0]       grant;
    logic             err_timeout;
    logic [CNT_W-1:0] byte_cnt;

    always #5 clock = ~clock;

    uart_tx_arbiter #(.BUSY_TIMEOUT(BUSY_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .resetb(resetb),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant(grant), .err_timeout(err_timeout),
        .byte_cnt(byte_cnt)
    );

    int checks = 0;
    int errors = 0;

    item_t      pend[$];
    item_t      expq[$];
    logic [7:0] seen[$];
    int         gap[3]      = '{0, 0, 0};
    int         gap_left[3] = '{0, 0, 0};
    int         m_last      = 2;
    int         uart_left   = 0;
    bit         uart_en     = 1'b1;
    bit         ext_busy    = 1'b0;
    int         completed   = 0;
    bit         prev_ub     = 1'b0;
    bit         prev_start  = 1'b0;
    bit         prev_err    = 1'b0;
    logic [7:0] held        = 8'h00;
    int         cyc         = 0;
    int         lat_cyc     = 0;
    int         last_lat    = -1;
    bit         lat_arm     = 1'b0;
    int         start_cyc   = 0;
    int         err_cyc     = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int find_src(input int s);
        for (int j = 0; j < pend.size(); j++)
            if (pend[j].src == 2'(s)) return j;
        return -1;
    endfunction

    function automatic logic [7:0] seen_at(input int k);
        if (k < seen.size()) return seen[k];
        return 8'hxx;
    endfunction

    task automatic push(input int s, input logic [7:0] d, input logic l);
        item_t it;
        it.src  = 2'(s);
        it.last = l;
        it.data = d;
        pend.push_back(it);
    endtask

    // Message-level model: whole messages go out in round-robin order starting after the last owner.
    task automatic plan();
        item_t work[$];
        int    s;
        int    idx;
        bit    done;
        work = pend;
        while (work.size() > 0) begin
            s = -1;
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (m_last + k) % 3;
                if (s < 0)
                    foreach (work[j]) if (work[j].src == 2'(c)) s = c;
            end
            done = 1'b0;
            while (!done) begin
                idx = -1;
                foreach (work[j]) if (idx < 0 && work[j].src == 2'(s)) idx = j;
                if (idx < 0) begin
                    done = 1'b1;
                end else begin
                    expq.push_back(work[idx]);
                    done = work[idx].last;
                    work.delete(idx);
                end
            end
            m_last = s;
        end
    endtask

    // Monitor, requester drivers and UART model, all away from the active edge.
    always @(negedge clock) begin
        logic [2:0]  v;
        logic [23:0] d;
        logic [2:0]  l;
        int          idx;
        bit          cur_ub;
        cyc++;
        if (!resetb) begin
            pend.delete();
            expq.delete();
            uart_left  = 0;
            completed  = 0;
            prev_ub    = 1'b0;
            prev_start = 1'b0;
            prev_err   = 1'b0;
            lat_arm    = 1'b0;
            held       = 8'h00;
            m_last     = 2;
            for (int i = 0; i < 3; i++) gap_left[i] = 0;
            req_valid = 3'b000;
            req_data  = 24'h0;
            req_last  = 3'b000;
            tx_busy   = ext_busy;
        end else begin
            cur_ub = (uart_left > 0);
            if (prev_ub && !cur_ub) completed++;
            prev_ub = cur_ub;
            check("byte_cnt", byte_cnt, completed % (1 << CNT_W));
            if (req_ready != 3'b000) begin
                check("ready_matches_grant", req_ready, grant);
                check("ready_onehot", $countones(req_ready), 1);
            end
            if (grant != 3'b000) check("grant_onehot", $countones(grant), 1);
            if (tx_start) begin
                check("start_while_busy", tx_busy, 0);
                check("start_one_cycle", prev_start, 0);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got start with tx_data 0x%0h, expected no start", tx_data);
                end else begin
                    item_t e;
                    e = expq.pop_front();
                    check("tx_data", tx_data, e.data);
                    check("grant_at_start", grant, 3'b001 << e.src);
                end
                seen.push_back(tx_data);
                held      = tx_data;
                start_cyc = cyc;
                if (lat_arm) begin
                    last_lat = cyc - lat_cyc;
                    lat_arm  = 1'b0;
                end
            end else if (tx_busy) begin
                check("tx_data_hold", tx_data, held);
            end
            if (err_timeout && !prev_err) err_cyc = cyc;
            prev_err   = err_timeout;
            prev_start = tx_start;

            for (int i = 0; i < 3; i++) begin
                if (req_ready[i]) begin
                    idx = find_src(i);
                    if (idx >= 0) pend.delete(idx);
                    gap_left[i] = gap[i];
                end
            end
            v = 3'b000;
            d = req_data;
            l = req_last;
            for (int i = 0; i < 3; i++) begin
                if (gap_left[i] > 0) begin
                    gap_left[i]--;
                end else begin
                    idx = find_src(i);
                    if (idx >= 0) begin
                        v[i]        = 1'b1;
                        d[i*8 +: 8] = pend[idx].data;
                        l[i]        = pend[idx].last;
                    end
                end
            end
            if (!lat_arm && req_valid == 3'b000 && v != 3'b000 && grant == 3'b000 && !tx_busy) begin
                lat_arm = 1'b1;
                lat_cyc = cyc;
            end
            req_valid = v;
            req_data  = d;
            req_last  = l;

            if (uart_left > 0) uart_left--;
            if (tx_start && uart_en) uart_left = UART_CYC;
            tx_busy = (uart_left > 0) || ext_busy;
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(posedge clock);
            #1;
            n++;
            if (pend.size() == 0 && expq.size() == 0 && grant == 3'b000 &&
                tx_busy == 1'b0 && uart_left == 0)
                done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no idle after %0d cycles, expected idle", name, budget);
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 resetb = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetb = 1'b1;
        seen.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_byte_cnt"}, byte_cnt, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        resetb = 1'b1;
        @(posedge clock);
        #1;

        // Single two-byte message from requester 0.
        seen.delete();
        push(0, 8'h3E, 1'b0);
        push(0, 8'h0A, 1'b1);
        plan();
        wait_idle(200, "single");
        check("single_count", seen.size(), 2);
        check("single_b0", seen_at(0), 8'h3E);
        check("single_b1", seen_at(1), 8'h0A);
        check("single_latency", last_lat, 2);
        check("single_byte_cnt", byte_cnt, 2);
        check("single_grant", grant, 0);

        // All three request together right after reset.
        do_reset();
        push(2, 8'h33, 1'b1);
        push(1, 8'h22, 1'b1);
        push(0, 8'h11, 1'b1);
        plan();
        wait_idle(200, "contention");
        check("cont_b0", seen_at(0), 8'h11);
        check("cont_b1", seen_at(1), 8'h22);
        check("cont_b2", seen_at(2), 8'h33);
        check("cont_byte_cnt", byte_cnt, 3);

        // Requester 0 pauses between bytes longer than a UART frame; requester 1 must still wait.
        seen.delete();
        gap[0] = 15;
        push(0, 8'hA1, 1'b0);
        push(0, 8'hA2, 1'b0);
        push(0, 8'hA3, 1'b1);
        push(1, 8'hB1, 1'b1);
        plan();
        wait_idle(300, "lock");
        gap[0] = 0;
        check("lock_b0", seen_at(0), 8'hA1);
        check("lock_b1", seen_at(1), 8'hA2);
        check("lock_b2", seen_at(2), 8'hA3);
        check("lock_b3", seen_at(3), 8'hB1);
        check("lock_byte_cnt", byte_cnt, 7);

        // No grant while the transmitter reports busy.
        seen.delete();
        ext_busy = 1'b1;
        push(2, 8'h5C, 1'b1);
        plan();
        repeat (8) @(posedge clock);
        #1;
        check("busy_hold_grant", grant, 0);
        check("busy_hold_starts", seen.size(), 0);
        ext_busy = 1'b0;
        wait_idle(100, "busy_hold");
        check("busy_hold_b0", seen_at(0), 8'h5C);
        check("busy_hold_byte_cnt", byte_cnt, 8);

        // Leave the pointer after requester 0, then reset during requester 1's transfer.
        push(0, 8'h01, 1'b1);
        plan();
        wait_idle(100, "pre_reset");
        push(1, 8'h71, 1'b0);
        push(1, 8'h72, 1'b1);
        plan();
        n = 0;
        while (!tx_busy && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("midreset_saw_busy", tx_busy, 1);
        repeat (3) @(posedge clock);
        #2 resetb = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clock);
        #1 resetb = 1'b1;
        seen.delete();
        push(2, 8'h92, 1'b1);
        push(0, 8'h90, 1'b1);
        plan();
        wait_idle(200, "after_reset");
        check("after_reset_b0", seen_at(0), 8'h90);
        check("after_reset_b1", seen_at(1), 8'h92);
        check("after_reset_byte_cnt", byte_cnt, 2);

        // Transmitter never goes busy.
        do_reset();
        uart_en = 1'b0;
        err_cyc = -1;
        push(0, 8'h5A, 1'b1);
        plan();
        wait_idle(100, "timeout");
        check("timeout_err", err_timeout, 1);
        check("timeout_delay", err_cyc - start_cyc, BUSY_TIMEOUT);
        check("timeout_grant", grant, 0);
        check("timeout_byte_cnt", byte_cnt, 0);
        check("timeout_starts", seen.size(), 1);

        // Counter wrap with the sticky flag still set.
        uart_en = 1'b1;
        seen.delete();
        for (int k = 0; k < 17; k++) push(1, 8'h40 + 8'(k), k == 16);
        plan();
        wait_idle(500, "wrap");
        check("wrap_count", seen.size(), 17);
        check("wrap_byte_cnt", byte_cnt, 1);
        check("wrap_err_sticky", err_timeout, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
